load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface: accepts one load/store request at a time from the
//  execute stage and drives the memory's fetch/write ports. For loads it sign/zero-extends the fetched
//  data. It waits on fetch_done/write_done, with a timeout. It returns a single response per request
//  through a valid/ready handshake.
// PARAMETERS
//  ADDR_WIDTH      32  address width, equal to the memory's address width
//  DATA_WIDTH      32  data width, a multiple of 8; DATA_BYTE_SIZE = DATA_WIDTH/8
//  TIMEOUT_CYCLES  16  cycles spent in LOAD/STORE without done before an error response; must be >=2
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        reset, asynchronous, active-high
//  req_valid       in   1        request present
//  req_ready       out  1        LSU can accept (IDLE only)
//  req_is_store    in   1        1 = store, 0 = load
//  req_addr        in   ADDR_W   byte address, any alignment
//  req_size        in   IDX+1    bytes to access, valid 1..DATA_BYTE_SIZE; IDX = $clog2(DATA_BYTE_SIZE)
//  req_signed      in   1        load: sign-extend (1) or zero-extend (0)
//  req_wdata       in   DATA_W   store data, low req_size bytes used
//  resp_valid      out  1        response present
//  resp_ready      in   1        consumer accepts response
//  resp_data       out  DATA_W   extended load data; 0 for stores and errors
//  resp_err        out  1        bad size or timeout
//  fetch_addr      out  ADDR_W   to memory
//  fetched_data    in   DATA_W   from memory, little-endian from fetch_addr
//  fetch_done      in   1        fetched_data is valid this cycle
//  write_addr      out  ADDR_W   to memory
//  write_data      out  DATA_W   to memory
//  bytes_to_write  out  IDX+1    to memory
//  write_activate  out  1        store pending
//  write_done      in   1        memory commits the write at the next posedge
// BEHAVIOUR
//  - Reset (async): state=IDLE; resp_valid, resp_err, write_activate=0; resp_data, timer and request regs=0.
//    Reset during LOAD/STORE/RESP abandons the operation: write_activate falls with rst and no response
//    is issued.
//  - States IDLE, LOAD, STORE, RESP; one request outstanding; req_ready = (state==IDLE).
//  - IDLE: on req_valid, latch addr/size/signed/wdata/is_store and clear the timer.
//    size==0 or size>DATA_BYTE_SIZE -> RESP with err=1, with no memory access; otherwise -> STORE or LOAD.
//  - fetch_addr/write_addr/write_data/bytes_to_write are driven from the latched regs in every state.
//    bytes_to_write = latched size in STORE, otherwise 0.
//  - LOAD: if fetch_done, register extend(fetched_data, size, signed) into resp_data and go to RESP with
//    err=0. extend: keep the low 8*size bits; fill above from bit 8*size-1 (signed) or with 0;
//    size==DATA_BYTE_SIZE passes data through.
//  - STORE: write_activate=1. It must depend only on state, never on write_done (the memory derives
//    write_done from it combinationally). When write_done is high, go to RESP with err=0 and resp_data=0.
//  - Timeout: the timer increments each cycle in LOAD/STORE. When timer==TIMEOUT_CYCLES-1 and done is low,
//    go to RESP with err=1 and resp_data=0. If done and the timeout occur in the same cycle, done wins.
//  - RESP: resp_valid=1, with resp_data/resp_err held stable until resp_ready; then go to IDLE.
//    A new request is accepted no earlier than the cycle after the handshake.
//  - Latency, req accept to resp_valid: load with fetch_done tied high = 2 cycles; store = 1 + wait cycles.
// STRUCTURE
//  - lsu_pkg: typedef enum logic [1:0] {LSU_IDLE, LSU_LOAD, LSU_STORE, LSU_RESP} lsu_state_t;
//    req/resp struct typedefs parameterised by DATA/ADDR widths, shared with the execute stage.
//  - Sub-module lsu_extend (combinational: data, size, signed -> extended data), reused by the writeback
//    path. FSM, timer and request regs stay in this module.
// TESTING
//  1 load size=1 signed, mem[0x10]=0x80, fetch_done=1 -> resp_data=0xFFFF_FF80, err=0, 2 cycles after accept.
//  2 load size=2 unsigned, addr=0x21 (unaligned), bytes 0xBEEF -> resp_data=0x0000_BEEF.
//  3 store size=4 data=0xDEADBEEF addr=0x40 against the memory model (write_done on alternate cycles)
//    -> write_activate held until write_done, then readback gives 0xDEADBEEF; store size=1 changes one byte.
//  4 req_size=0 and req_size=5 -> resp_err=1 after 1 cycle; write_activate never asserted.
//  5 write_done tied 0 -> resp_err=1 after exactly TIMEOUT_CYCLES cycles in STORE; done on the last cycle -> err=0.
//  6 resp_ready low for 5 cycles -> resp_valid/resp_data stable, req_ready=0; rst pulse mid-STORE ->
//    write_activate=0 immediately, state IDLE, no response.

Source files
------------

// File: rtl/lsu_pkg.sv
// Types and defaults shared by the load/store unit, its extend helper and the execute stage.
package lsu_pkg;
  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;
  localparam int LSU_BYTES  = LSU_DATA_W / 8;
  localparam int LSU_IDX    = $clog2(LSU_BYTES);

  typedef enum logic [1:0] {LSU_IDLE, LSU_LOAD, LSU_STORE, LSU_RESP} lsu_state_t;

  typedef struct packed {
    logic                  is_store;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_IDX:0]      size;
    logic                  is_signed;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_req_t;

  typedef struct packed {
    logic [LSU_DATA_W-1:0] data;
    logic                  err;
  } lsu_resp_t;

  // A request size is legal when it names between one byte and a full data word.
  function automatic logic lsu_size_ok(input int size, input int bytes);
    return (size >= 1) && (size <= bytes);
  endfunction
endpackage

// File: rtl/lsu_extend.sv
// Keeps the low i_size bytes of i_data and fills the rest with the sign bit or zeros.
module lsu_extend #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX        = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [IDX:0]          i_size,
  input  logic                  i_signed,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic w_fill;

  always_comb begin
    w_fill = 1'b0;
    // The fill bit is the top bit of the highest kept byte.
    for (int b = 0; b < BYTES; b++) begin
      if (int'(i_size) == b + 1) w_fill = i_signed & i_data[8*b+7];
    end
    for (int b = 0; b < BYTES; b++) begin
      o_data[8*b +: 8] = (b < int'(i_size)) ? i_data[8*b +: 8] : {8{w_fill}};
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store in flight, done/timeout wait, one response per request.
// Handshakes: a transfer happens on a rising edge where both valid and ready are high.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int ADDR_WIDTH     = LSU_ADDR_W,
  parameter  int DATA_WIDTH     = LSU_DATA_W,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int DATA_BYTE_SIZE = DATA_WIDTH / 8,
  localparam int IDX            = $clog2(DATA_BYTE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [IDX:0]          req_size,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic [DATA_WIDTH-1:0] fetched_data,
  input  logic                  fetch_done,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [IDX:0]          bytes_to_write,
  output logic                  write_activate,
  input  logic                  write_done,
  output lsu_state_t            dbg_state
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_t            r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [IDX:0]          r_size;
  logic                  r_signed, r_is_store;
  logic [DATA_WIDTH-1:0] r_wdata, r_resp_data;
  logic                  r_resp_err;
  logic [TW-1:0]         r_timer;

  logic                  w_accept, w_resp_set, w_resp_err, w_done, w_timeout;
  logic [DATA_WIDTH-1:0] w_resp_data, w_ext;

  lsu_extend #(.DATA_WIDTH(DATA_WIDTH), .IDX(IDX)) u_extend (
    .i_data   (fetched_data),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_resp_set   = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_data  = '0;
    w_done       = r_is_store ? write_done : fetch_done;
    w_timeout    = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    case (r_state)
      LSU_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (!lsu_size_ok(int'(req_size), DATA_BYTE_SIZE)) begin
            w_next_state = LSU_RESP;
            w_resp_set   = 1'b1;
            w_resp_err   = 1'b1;
          end else begin
            w_next_state = req_is_store ? LSU_STORE : LSU_LOAD;
          end
        end
      end
      // Done takes priority over a timeout landing in the same cycle.
      LSU_LOAD, LSU_STORE: begin
        if (w_done) begin
          w_next_state = LSU_RESP;
          w_resp_set   = 1'b1;
          w_resp_data  = r_is_store ? '0 : w_ext;
        end else if (w_timeout) begin
          w_next_state = LSU_RESP;
          w_resp_set   = 1'b1;
          w_resp_err   = 1'b1;
        end
      end
      LSU_RESP: begin
        if (resp_ready) w_next_state = LSU_IDLE;
      end
      default: w_next_state = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_is_store  <= 1'b0;
      r_wdata     <= '0;
      r_timer     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr;
        r_size     <= req_size;
        r_signed   <= req_signed;
        r_is_store <= req_is_store;
        r_wdata    <= req_wdata;
        r_timer    <= '0;
      end else if (r_state == LSU_LOAD || r_state == LSU_STORE) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_resp_set) begin
        r_resp_data <= w_resp_data;
        r_resp_err  <= w_resp_err;
      end
    end
  end

  // write_activate depends on state alone; the memory builds write_done from it.
  assign write_activate = (r_state == LSU_STORE);
  assign bytes_to_write = write_activate ? r_size : '0;
  assign req_ready      = (r_state == LSU_IDLE);
  assign resp_valid     = (r_state == LSU_RESP);
  assign resp_data      = r_resp_data;
  assign resp_err       = r_resp_err;
  assign fetch_addr     = r_addr;
  assign write_addr     = r_addr;
  assign write_data     = r_wdata;
  assign dbg_state      = r_state;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus hand sequences for wait, timeout, backpressure, reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_store, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic [31:0] fetch_addr, fetched_data, write_addr, write_data;
  logic        fetch_done, write_activate, write_done;
  logic [2:0]  bytes_to_write;
  lsu_state_t  dbg_state;

  int          n_cmp = 0;
  int          n_miss = 0;
  int          wd_mode;
  logic        fetch_en;
  logic        wd_phase;
  int          st_cnt;
  logic [7:0]  mem [256];

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .fetch_addr(fetch_addr), .fetched_data(fetched_data), .fetch_done(fetch_done),
    .write_addr(write_addr), .write_data(write_data), .bytes_to_write(bytes_to_write),
    .write_activate(write_activate), .write_done(write_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // memory model: little-endian, write commits on the edge where write_done is high
  assign fetch_done = fetch_en;
  assign write_done = write_activate & ((wd_mode == 2) || (wd_mode == 1 && wd_phase) ||
                                        (wd_mode == 3 && st_cnt == 15));

  always_comb begin
    for (int i = 0; i < 4; i++) fetched_data[8*i +: 8] = mem[fetch_addr[7:0] + 8'(i)];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      wd_phase <= 1'b0;
      st_cnt   <= 0;
    end else begin
      wd_phase <= ~wd_phase;
      st_cnt   <= write_activate ? st_cnt + 1 : 0;
      if (write_done) begin
        for (int i = 0; i < 4; i++)
          if (i < int'(bytes_to_write)) mem[write_addr[7:0] + 8'(i)] <= write_data[8*i +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // driver: issue one request, wait for the response, optionally stall resp_ready for hold cycles
  task automatic do_req(input logic st, input logic [31:0] addr, input logic [2:0] size,
                        input logic sgn, input logic [31:0] wd, input int hold,
                        output logic [31:0] data, output logic err, output int lat,
                        output int wa, output logic [2:0] btw, output int hold_bad);
    chk("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wa = 0; hold_bad = 0;
    btw = bytes_to_write;
    while (!resp_valid && lat < 200) begin
      if (write_activate) wa++;
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
    data = resp_data;
    err  = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== data || resp_err !== err)
        hold_bad++;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        sgn;
    logic [31:0] wd;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_wa;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  logic [31:0] data;
  logic        err;
  int          lat, wa, hb, rv_cnt;
  logic [2:0]  btw;

  initial begin
    vecs[0]  = '{1'b1, 32'h10, 3'd1, 1'b0, 32'h0000_0080, 32'h0000_0000, 1'b0, 2, 1};
    vecs[1]  = '{1'b1, 32'h21, 3'd2, 1'b0, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 2, 1};
    vecs[2]  = '{1'b0, 32'h10, 3'd1, 1'b1, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 0};
    vecs[3]  = '{1'b0, 32'h10, 3'd1, 1'b0, 32'h0,         32'h0000_0080, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 32'h21, 3'd2, 1'b0, 32'h0,         32'h0000_BEEF, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 32'h21, 3'd2, 1'b1, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 32'h21, 3'd4, 1'b1, 32'h0,         32'h0000_BEEF, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 32'h30, 3'd4, 1'b0, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 1};
    vecs[8]  = '{1'b0, 32'h30, 3'd4, 1'b1, 32'h0,         32'h1122_3344, 1'b0, 2, 0};
    vecs[9]  = '{1'b1, 32'h30, 3'd1, 1'b0, 32'hAAAA_AA99, 32'h0000_0000, 1'b0, 2, 1};
    vecs[10] = '{1'b0, 32'h30, 3'd4, 1'b0, 32'h0,         32'h1122_3399, 1'b0, 2, 0};
    vecs[11] = '{1'b0, 32'h31, 3'd3, 1'b1, 32'h0,         32'h0011_2233, 1'b0, 2, 0};
    vecs[12] = '{1'b1, 32'h50, 3'd2, 1'b0, 32'hFFFF_8001, 32'h0000_0000, 1'b0, 2, 1};
    vecs[13] = '{1'b0, 32'h50, 3'd4, 1'b1, 32'h0,         32'h0000_8001, 1'b0, 2, 0};
    vecs[14] = '{1'b0, 32'h50, 3'd2, 1'b1, 32'h0,         32'hFFFF_8001, 1'b0, 2, 0};
    vecs[15] = '{1'b0, 32'h20, 3'd3, 1'b1, 32'h0,         32'hFFBE_EF00, 1'b0, 2, 0};
    vecs[16] = '{1'b0, 32'h10, 3'd0, 1'b1, 32'h0,         32'h0000_0000, 1'b1, 1, 0};
    vecs[17] = '{1'b0, 32'h10, 3'd5, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1, 0};
    vecs[18] = '{1'b1, 32'h60, 3'd0, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b1, 1, 0};
    vecs[19] = '{1'b1, 32'h60, 3'd7, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b1, 1, 0};
    vecs[20] = '{1'b0, 32'h60, 3'd4, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 2, 0};

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b0; fetch_en = 1'b1; wd_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst resp_data", resp_data, 32'd0);
    chk("rst write_activate", {31'b0, write_activate}, 32'd0);
    chk("rst bytes_to_write", {29'b0, bytes_to_write}, 32'd0);
    chk("rst fetch_addr", fetch_addr, 32'd0);
    chk("rst state", 32'(dbg_state), 32'(LSU_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      do_req(vecs[v].st, vecs[v].addr, vecs[v].size, vecs[v].sgn, vecs[v].wd, 0,
             data, err, lat, wa, btw, hb);
      chk($sformatf("v%0d data", v), data, vecs[v].exp_data);
      chk($sformatf("v%0d err", v), {31'b0, err}, {31'b0, vecs[v].exp_err});
      chk($sformatf("v%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d wa_cycles", v), 32'(wa), 32'(vecs[v].exp_wa));
      chk($sformatf("v%0d bytes_to_write", v), {29'b0, btw},
          (vecs[v].exp_wa > 0) ? {29'b0, vecs[v].size} : 32'd0);
    end

    // store with write_done on alternate cycles, then readback and a single-byte overwrite
    wd_mode = 1;
    do_req(1'b1, 32'h40, 3'd4, 1'b0, 32'hDEAD_BEEF, 0, data, err, lat, wa, btw, hb);
    chk("alt store err", {31'b0, err}, 32'd0);
    chk("alt store data", data, 32'd0);
    chk("alt store wa held", 32'(wa), 32'(lat - 1));
    chk("alt store btw", {29'b0, btw}, 32'd4);
    do_req(1'b0, 32'h40, 3'd4, 1'b0, 32'h0, 0, data, err, lat, wa, btw, hb);
    chk("alt readback", data, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h41, 3'd1, 1'b0, 32'h0000_0055, 0, data, err, lat, wa, btw, hb);
    chk("alt byte store err", {31'b0, err}, 32'd0);
    chk("alt byte store wa held", 32'(wa), 32'(lat - 1));
    do_req(1'b0, 32'h40, 3'd4, 1'b0, 32'h0, 0, data, err, lat, wa, btw, hb);
    chk("alt byte readback", data, 32'hDEAD_55EF);

    // store timeout, then done arriving on the final allowed cycle
    wd_mode = 0;
    do_req(1'b1, 32'h48, 3'd2, 1'b0, 32'h0000_1234, 0, data, err, lat, wa, btw, hb);
    chk("store timeout err", {31'b0, err}, 32'd1);
    chk("store timeout data", data, 32'd0);
    chk("store timeout latency", 32'(lat), 32'd17);
    chk("store timeout wa_cycles", 32'(wa), 32'd16);
    wd_mode = 3;
    do_req(1'b1, 32'h48, 3'd2, 1'b0, 32'h0000_1234, 0, data, err, lat, wa, btw, hb);
    chk("last-cycle done err", {31'b0, err}, 32'd0);
    chk("last-cycle done latency", 32'(lat), 32'd17);
    chk("last-cycle done wa_cycles", 32'(wa), 32'd16);
    wd_mode = 2;
    do_req(1'b0, 32'h48, 3'd4, 1'b0, 32'h0, 0, data, err, lat, wa, btw, hb);
    chk("last-cycle readback", data, 32'h0000_1234);

    // load timeout
    fetch_en = 1'b0;
    do_req(1'b0, 32'h10, 3'd1, 1'b1, 32'h0, 0, data, err, lat, wa, btw, hb);
    chk("load timeout err", {31'b0, err}, 32'd1);
    chk("load timeout data", data, 32'd0);
    chk("load timeout latency", 32'(lat), 32'd17);
    fetch_en = 1'b1;

    // response backpressure
    do_req(1'b0, 32'h10, 3'd1, 1'b1, 32'h0, 5, data, err, lat, wa, btw, hb);
    chk("stall data", data, 32'hFFFF_FF80);
    chk("stall err", {31'b0, err}, 32'd0);
    chk("stall unstable cycles", 32'(hb), 32'd0);

    // reset in the middle of a store abandons it
    wd_mode = 0;
    req_valid = 1'b1; req_is_store = 1'b1; req_addr = 32'h70; req_size = 3'd4;
    req_signed = 1'b0; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid-store write_activate", {31'b0, write_activate}, 32'd1);
    chk("mid-store state", 32'(dbg_state), 32'(LSU_STORE));
    #2 rst = 1'b1;
    #1;
    chk("rst pulse write_activate", {31'b0, write_activate}, 32'd0);
    chk("rst pulse state", 32'(dbg_state), 32'(LSU_IDLE));
    chk("rst pulse resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rv_cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (resp_valid) rv_cnt++;
    end
    chk("after rst no response", 32'(rv_cnt), 32'd0);
    wd_mode = 2;
    do_req(1'b0, 32'h70, 3'd4, 1'b0, 32'h0, 0, data, err, lat, wa, btw, hb);
    chk("after rst load", data, 32'd0);
    chk("after rst load err", {31'b0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule
